// File: rtl/mantissa_mult_arbiter_if.sv
// Requester/response bundle for the shared mantissa multiplier arbiter.
// master = requester side, slave = arbiter side.
interface mantissa_mult_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int MW    = 24,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*MW-1:0] req_a;
  logic [N_REQ*MW-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                drain;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*MW-1:0]     rsp_p;
  logic                idle;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output drain,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_p,
    input  idle
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  drain,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_p,
    output idle
  );
endinterface

// File: rtl/mantissa_mult_arbiter.sv
// Round-robin sharing of one pipelined mantissa multiplier,
// tagging each product with its requester ID.
module mantissa_mult_arbiter #(
  parameter int N_REQ = 4,
  parameter int MW    = 24,
  parameter int LAT   = 3,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mantissa_mult_arbiter_if.slave bus,
  output logic [MW-1:0]          mul_a,
  output logic [MW-1:0]          mul_b,
  input  logic [2*MW-1:0]        mul_p
);
  localparam int CW = $clog2(LAT + 2);

  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  idx;
  logic [IDW-1:0]  win_id;
  logic            win_vld;
  logic            hs;
  logic [LAT-1:0]  tv_q;
  logic [IDW-1:0]  tid_q [LAT];
  logic            rv_q;
  logic [IDW-1:0]  rid_q;
  logic [2*MW-1:0] rp_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  // First valid requester after the last winner
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(rr_q) + k) % N_REQ);
      if (!win_vld && bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

  assign hs = win_vld & ~bus.drain & rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[win_id] = 1'b1;
  end

  assign mul_a = hs ? bus.req_a[int'(win_id)*MW +: MW] : '0;
  assign mul_b = hs ? bus.req_b[int'(win_id)*MW +: MW] : '0;
  assign rr_d  = hs ? win_id : rr_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({hs, rv_q})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= IDW'(N_REQ - 1);
      tv_q  <= '0;
      for (int i = 0; i < LAT; i++)
        tid_q[i] <= '0;
      rv_q  <= 1'b0;
      rid_q <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q     <= rr_d;
      tv_q[0]  <= hs;
      tid_q[0] <= win_id;
      for (int i = 1; i < LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tid_q[i] <= tid_q[i-1];
      end
      rv_q  <= tv_q[LAT-1];
      rid_q <= tid_q[LAT-1];
      if (tv_q[LAT-1]) rp_q <= mul_p;
      cnt_q <= cnt_d;
    end
  end

  assign bus.rsp_valid = rv_q;
  assign bus.rsp_id    = rid_q;
  assign bus.rsp_p     = rp_q;
  assign bus.idle      = (cnt_q == '0) & ~|tv_q;

  cnt_bound: assert property (
    @(posedge clk) disable iff (!rst_n) cnt_q <= CW'(LAT + 1)
  );
endmodule
